// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard/redirect inputs, pipeline register controls and status of the stall sequencer
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 32);
   logic HazardStall, BranchTaken, JumpTaken, MemBusy, CntClear;
   logic PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Write;
   logic [1:0] State;
   logic [CNT_W-1:0] StallCount, FlushCount, MemWaitCount;
   logic StallTimeout;
   modport master(
      input HazardStall, BranchTaken, JumpTaken, MemBusy, CntClear,
      output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Write,
      output State, StallCount, FlushCount, MemWaitCount, StallTimeout
   );
   modport slave(
      output HazardStall, BranchTaken, JumpTaken, MemBusy, CntClear,
      input PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Write,
      input State, StallCount, FlushCount, MemWaitCount, StallTimeout
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer with post-reset fill, saturating perf counters and stall watchdog
module pipeline_stall_ctrl #(
   parameter int FILL_CYCLES = 4,
   parameter int MAX_STALL = 16,
   parameter int CNT_W = 32
) (
   input logic Clk,
   input logic Rst,
   pipeline_stall_ctrl_if.master bus
);
   typedef enum logic [1:0] {FILL = 2'b00, RUN = 2'b01, HAZ = 2'b10, MEMW = 2'b11} state_t;
   localparam int FW = FILL_CYCLES > 1 ? $clog2(FILL_CYCLES) : 1;
   localparam int SW = $clog2(MAX_STALL + 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(FILL_CYCLES - 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   state_t state, nextState;
   logic [FW-1:0] fillCnt;
   logic [SW-1:0] stallRun;
   logic [CNT_W-1:0] stallCnt, flushCnt, memWaitCnt;
   logic timeout;
   logic isFill, isMemW, isHaz, isRedir;
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return v == CNT_MAX ? v : v + 1'b1;
   endfunction
   // Priority FILL > MEMW > HAZ > REDIRECT > RUN; a stall suppresses the redirect since operands are not ready
   always_comb begin
      isFill = Rst || state == FILL;
      isMemW = !isFill && bus.MemBusy;
      isHaz = !isFill && !bus.MemBusy && bus.HazardStall;
      isRedir = !isFill && !bus.MemBusy && !bus.HazardStall && (bus.BranchTaken || bus.JumpTaken);
      nextState = state == FILL ? (fillCnt == FILL_LAST ? RUN : FILL)
                : bus.MemBusy ? MEMW : bus.HazardStall ? HAZ : RUN;
      bus.PCWrite = !(isFill || isMemW || isHaz);
      bus.IF_ID_Write = !(isFill || isMemW || isHaz);
      bus.IF_ID_Flush = isFill || isRedir;
      bus.ID_EX_Bubble = isFill || isHaz;
      bus.EX_MEM_Write = !isMemW;
      bus.MEM_WB_Write = !isMemW;
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= FILL;
         fillCnt <= '0;
         stallRun <= '0;
         stallCnt <= '0;
         flushCnt <= '0;
         memWaitCnt <= '0;
         timeout <= 1'b0;
      end else begin
         state <= nextState;
         if (isFill) fillCnt <= fillCnt + 1'b1;
         stallRun <= (isMemW || isHaz) ? (stallRun == STALL_MAX ? stallRun : stallRun + 1'b1)
                   : isFill ? stallRun : '0;
         timeout <= timeout || stallRun == STALL_MAX;
         stallCnt <= bus.CntClear ? '0 : isHaz ? satInc(stallCnt) : stallCnt;
         flushCnt <= bus.CntClear ? '0 : isRedir ? satInc(flushCnt) : flushCnt;
         memWaitCnt <= bus.CntClear ? '0 : isMemW ? satInc(memWaitCnt) : memWaitCnt;
      end
   end
   assign bus.State = state;
   assign bus.StallCount = stallCnt;
   assign bus.FlushCount = flushCnt;
   assign bus.MemWaitCount = memWaitCnt;
   assign bus.StallTimeout = timeout;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed vector table, hand corner sequences and random stimulus against a class-level model
module tb_pipeline_stall_ctrl;
   localparam int FILLN = 4;
   localparam int MAXS = 16;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;
   localparam int C_FILL = 0, C_MEMW = 1, C_HAZ = 2, C_REDIR = 3, C_RUN = 4;
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   int fillLeft, mState, mStall, mFlush, mWait, consec, cls;
   bit mTo;
   pipeline_stall_ctrl_if #(.CNT_W(CW)) bus();
   pipeline_stall_ctrl #(.FILL_CYCLES(FILLN), .MAX_STALL(MAXS), .CNT_W(CW)) dut(.Clk(clk), .Rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [5:0] in;
      logic [5:0] ctl;
      logic [1:0] st;
      int sc, fc, mc;
   } vec_t;
   vec_t tbl[18];
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask
   function automatic logic [31:0] ctlNow();
      return {26'd0, bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Bubble, bus.EX_MEM_Write, bus.MEM_WB_Write};
   endfunction
   function automatic logic [31:0] regsNow();
      return {17'd0, bus.State, bus.StallCount, bus.FlushCount, bus.MemWaitCount, bus.StallTimeout};
   endfunction
   function automatic logic [31:0] ctlOf(input int c);
      return c == C_FILL ? 32'b001111 : c == C_MEMW ? 32'b000000 : c == C_HAZ ? 32'b000111
           : c == C_REDIR ? 32'b111011 : 32'b110011;
   endfunction
   function automatic logic [31:0] regsOf(input int st, input int sc, input int fc, input int mc, input bit to);
      return {17'd0, st[1:0], sc[3:0], fc[3:0], mc[3:0], to};
   endfunction
   function automatic int sat(input int v, input int lim);
      return v < lim ? v + 1 : lim;
   endfunction
   task automatic applyIn(input logic [5:0] v);
      {rst, bus.HazardStall, bus.BranchTaken, bus.JumpTaken, bus.MemBusy, bus.CntClear} = v;
      cls = (rst || fillLeft > 0) ? C_FILL : bus.MemBusy ? C_MEMW : bus.HazardStall ? C_HAZ
          : (bus.BranchTaken || bus.JumpTaken) ? C_REDIR : C_RUN;
      #2;
   endtask
   task automatic checkModel();
      chk("ctl", ctlNow(), ctlOf(cls));
      chk("regs", regsNow(), regsOf(mState, mStall, mFlush, mWait, mTo));
   endtask
   task automatic modelReset();
      fillLeft = FILLN;
      mState = 0; mStall = 0; mFlush = 0; mWait = 0; consec = 0; mTo = 0;
   endtask
   task automatic advance();
      @(posedge clk);
      #1;
      if (rst) modelReset();
      else begin
         if (cls == C_FILL) begin
            fillLeft--;
            mState = fillLeft == 0 ? 1 : 0;
         end else mState = cls == C_MEMW ? 3 : cls == C_HAZ ? 2 : 1;
         mTo = mTo | (consec >= MAXS);
         if (cls == C_MEMW || cls == C_HAZ) consec = sat(consec, MAXS);
         else if (cls != C_FILL) consec = 0;
         if (bus.CntClear) begin
            mStall = 0; mFlush = 0; mWait = 0;
         end else begin
            if (cls == C_HAZ) mStall = sat(mStall, SAT);
            if (cls == C_REDIR) mFlush = sat(mFlush, SAT);
            if (cls == C_MEMW) mWait = sat(mWait, SAT);
         end
      end
   endtask
   task automatic runCycle(input logic [5:0] v);
      applyIn(v);
      checkModel();
      advance();
   endtask
   initial begin
      // in = {Rst, HazardStall, BranchTaken, JumpTaken, MemBusy, CntClear}
      tbl[0] = '{6'b010010, 6'b001111, 2'd0, 0, 0, 0};
      tbl[1] = '{6'b010010, 6'b001111, 2'd0, 0, 0, 0};
      tbl[2] = '{6'b010010, 6'b001111, 2'd0, 0, 0, 0};
      tbl[3] = '{6'b010010, 6'b001111, 2'd0, 0, 0, 0};
      tbl[4] = '{6'b010010, 6'b000000, 2'd1, 0, 0, 0};
      tbl[5] = '{6'b011000, 6'b000111, 2'd3, 0, 0, 1};
      tbl[6] = '{6'b011000, 6'b000111, 2'd2, 1, 0, 1};
      tbl[7] = '{6'b001000, 6'b111011, 2'd2, 2, 0, 1};
      tbl[8] = '{6'b000000, 6'b110011, 2'd1, 2, 1, 1};
      tbl[9] = '{6'b010011, 6'b000000, 2'd1, 2, 1, 1};
      tbl[10] = '{6'b010010, 6'b000000, 2'd3, 0, 0, 0};
      tbl[11] = '{6'b010010, 6'b000000, 2'd3, 0, 0, 1};
      tbl[12] = '{6'b010010, 6'b000000, 2'd3, 0, 0, 2};
      tbl[13] = '{6'b000000, 6'b110011, 2'd3, 0, 0, 3};
      tbl[14] = '{6'b000101, 6'b111011, 2'd1, 0, 0, 3};
      tbl[15] = '{6'b000000, 6'b110011, 2'd1, 0, 0, 0};
      tbl[16] = '{6'b100010, 6'b001111, 2'd1, 0, 0, 0};
      tbl[17] = '{6'b011010, 6'b001111, 2'd0, 0, 0, 0};
      {rst, bus.HazardStall, bus.BranchTaken, bus.JumpTaken, bus.MemBusy, bus.CntClear} = 6'b110011;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      foreach (tbl[i]) begin
         applyIn(tbl[i].in);
         chk($sformatf("vec%0d_ctl", i), ctlNow(), {26'd0, tbl[i].ctl});
         chk($sformatf("vec%0d_regs", i), regsNow(), regsOf(tbl[i].st, tbl[i].sc, tbl[i].fc, tbl[i].mc, 1'b0));
         checkModel();
         advance();
      end
      repeat (5) runCycle(6'b000000);
      // watchdog: 15 stalls must not trip, 16 must, and the flag sticks until reset
      repeat (15) runCycle(6'b010000);
      repeat (3) runCycle(6'b000000);
      chk("wd_15", {31'd0, bus.StallTimeout}, 32'd0);
      for (int i = 0; i < 16; i++) runCycle(i % 2 ? 6'b000010 : 6'b010000);
      repeat (3) runCycle(6'b000000);
      chk("wd_16", {31'd0, bus.StallTimeout}, 32'd1);
      repeat (5) runCycle(6'b001000);
      chk("wd_sticky", {31'd0, bus.StallTimeout}, 32'd1);
      repeat (20) runCycle(6'b000100);
      chk("flush_sat", {28'd0, bus.FlushCount}, SAT);
      runCycle(6'b001001);
      chk("flush_clr", {28'd0, bus.FlushCount}, 32'd0);
      repeat (3) runCycle(6'b000010);
      runCycle(6'b100010);
      chk("rst_mid_wait", regsNow(), 32'd0);
      for (int i = 0; i < FILLN; i++) begin
         applyIn(6'b011010);
         chk($sformatf("refill%0d", i), ctlNow(), 32'b001111);
         checkModel();
         advance();
      end
      applyIn(6'b011010);
      chk("after_fill", ctlNow(), 32'b000000);
      checkModel();
      advance();
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] v;
         v[5] = $urandom_range(63) == 0;
         v[4] = $urandom_range(2) == 0;
         v[3] = $urandom_range(3) == 0;
         v[2] = $urandom_range(3) == 0;
         v[1] = $urandom_range(3) == 0;
         v[0] = $urandom_range(31) == 0;
         runCycle(v);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
